// File: rtl/i2c_arb_pkg.sv
// ============================================================================
// Module  : i2c_arb_pkg
// Brief   : Shared types and field widths for the I2C bus arbiter.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package i2c_arb_pkg;

    localparam int CHIP_ADDR_W = 7;
    localparam int REG_ADDR_W  = 8;
    localparam int DATA_W      = 8;

    localparam logic [2:0] I2C_ST_TIMEOUT = 3'b111;

    typedef enum logic [1:0] {
        s_idle    = 2'd0,
        s_issue   = 2'd1,
        s_wait    = 2'd2,
        s_release = 2'd3
    } arb_state_t;

    // Client index width; a single client still needs a 1-bit index.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/rr_pick.sv
// ============================================================================
// Module  : rr_pick
// Brief   : Combinational round-robin picker; search starts after last_served.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_pick #(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last_served,
    output logic [NUM_REQ-1:0] winner,
    output logic [IDX_W-1:0]   winner_idx,
    output logic               valid
);

    int   w_j;
    logic w_found;

    always_comb begin
        winner     = '0;
        winner_idx = '0;
        w_found    = 1'b0;
        w_j        = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            w_j = int'(last_served) + k;
            if (w_j >= NUM_REQ) w_j = w_j - NUM_REQ;
            if (!w_found && req[w_j]) begin
                w_found     = 1'b1;
                winner[w_j] = 1'b1;
                winner_idx  = IDX_W'(w_j);
            end
        end
        valid = w_found;
    end

endmodule

`default_nettype wire

// File: rtl/i2c_bus_arbiter.sv
// ============================================================================
// Module  : i2c_bus_arbiter
// Brief   : Round-robin sharing of one i2c_master among NUM_REQ clients.
//           Define I2C_ARB_TIMEOUT_EN to enable the s_wait watchdog.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module i2c_bus_arbiter
    import i2c_arb_pkg::*;
#(
    parameter int NUM_REQ        = 2,
    parameter int TIMEOUT_CYCLES = 2000000
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUM_REQ-1:0]             req,
    input  logic [NUM_REQ-1:0]             req_rw,
    input  logic [CHIP_ADDR_W*NUM_REQ-1:0] req_chip_addr,
    input  logic [REG_ADDR_W*NUM_REQ-1:0]  req_reg_addr,
    input  logic [DATA_W*NUM_REQ-1:0]      req_wdata,
    output logic [NUM_REQ-1:0]             grant,
    output logic [NUM_REQ-1:0]             req_done,
    output logic [DATA_W-1:0]              rdata,
    output logic [2:0]                     rstatus,
    output logic [CHIP_ADDR_W-1:0]         m_chip_addr,
    output logic [REG_ADDR_W-1:0]          m_reg_addr,
    output logic [DATA_W-1:0]              m_data_in,
    output logic                           m_write_en,
    output logic                           m_read_en,
    input  logic                           m_done,
    input  logic                           m_busy,
    input  logic [2:0]                     m_status,
    input  logic [DATA_W-1:0]              m_data_out
);

    localparam int IDX_W = idx_width(NUM_REQ);

    if (NUM_REQ < 1 || NUM_REQ > 8 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("i2c_bus_arbiter: parameter out of range");
    end

    arb_state_t         r_state;
    arb_state_t         w_next;
    logic [IDX_W-1:0]   r_last;
    logic [IDX_W-1:0]   r_owner;
    logic               r_rw;
    logic [NUM_REQ-1:0] w_win;
    logic [IDX_W-1:0]   w_win_idx;
    logic               w_win_valid;
    logic               w_start;
    logic               w_finish;
    logic               w_timeout;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_pick (
        .req         (req),
        .last_served (r_last),
        .winner      (w_win),
        .winner_idx  (w_win_idx),
        .valid       (w_win_valid)
    );

`ifdef I2C_ARB_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TO_W-1:0] r_to_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_to_cnt <= '0;
        end else if (r_state == s_wait) begin
            r_to_cnt <= r_to_cnt + 1'b1;
        end else begin
            r_to_cnt <= '0;
        end
    end

    assign w_timeout = (r_state == s_wait) && !m_done &&
                       (r_to_cnt == TO_W'(TIMEOUT_CYCLES));
`else
    assign w_timeout = 1'b0;
`endif

    assign w_start  = (r_state == s_idle) && !m_busy && w_win_valid;
    assign w_finish = (r_state == s_wait) && (m_done || w_timeout);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= s_idle;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            s_idle:    if (w_start)  w_next = s_issue;
            s_issue:                 w_next = s_wait;
            s_wait:    if (w_finish) w_next = s_release;
            s_release:               w_next = s_idle;
            default:                 w_next = s_idle;
        endcase
    end

    // Operands are latched only at grant, so client-side changes after that are invisible.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            grant       <= '0;
            req_done    <= '0;
            rdata       <= '0;
            rstatus     <= '0;
            m_chip_addr <= '0;
            m_reg_addr  <= '0;
            m_data_in   <= '0;
            m_write_en  <= 1'b0;
            m_read_en   <= 1'b0;
            r_rw        <= 1'b0;
            r_owner     <= '0;
            r_last      <= IDX_W'(NUM_REQ - 1);
        end else begin
            m_write_en <= 1'b0;
            m_read_en  <= 1'b0;
            req_done   <= '0;
            if (w_start) begin
                grant       <= w_win;
                r_owner     <= w_win_idx;
                r_rw        <= req_rw[w_win_idx];
                m_chip_addr <= req_chip_addr[w_win_idx*CHIP_ADDR_W +: CHIP_ADDR_W];
                m_reg_addr  <= req_reg_addr[w_win_idx*REG_ADDR_W +: REG_ADDR_W];
                m_data_in   <= req_wdata[w_win_idx*DATA_W +: DATA_W];
            end
            if (r_state == s_issue) begin
                m_write_en <= !r_rw;
                m_read_en  <= r_rw;
            end
            if (w_finish) begin
                req_done <= grant;
                if (m_done) begin
                    rdata   <= m_data_out;
                    rstatus <= m_status;
                end else begin
                    rdata   <= '0;
                    rstatus <= I2C_ST_TIMEOUT;
                end
            end
            if (r_state == s_release) begin
                grant  <= '0;
                r_last <= r_owner;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_i2c_bus_arbiter.sv
// ============================================================================
// Module  : tb_i2c_bus_arbiter
// Brief   : Directed + randomized bench with a round-robin reference model.
// Revision: 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_i2c_bus_arbiter;
    import i2c_arb_pkg::*;

    localparam int N = 2;

    logic           clk   = 1'b0;
    logic           reset = 1'b0;
    logic [N-1:0]   req   = '0;
    logic [N-1:0]   req_rw = '0;
    logic [6:0]     c_chip [N];
    logic [7:0]     c_reg  [N];
    logic [7:0]     c_wd   [N];
    logic [7*N-1:0] req_chip_addr;
    logic [8*N-1:0] req_reg_addr;
    logic [8*N-1:0] req_wdata;
    logic [N-1:0]   grant, req_done;
    logic [7:0]     rdata;
    logic [2:0]     rstatus;
    logic [6:0]     m_chip_addr;
    logic [7:0]     m_reg_addr, m_data_in;
    logic           m_write_en, m_read_en;
    logic           m_done = 1'b0;
    logic           m_busy = 1'b0;
    logic [2:0]     m_status = '0;
    logic [7:0]     m_data_out = '0;

    int errors = 0;
    int checks = 0;
    int last_m = N - 1;

    for (genvar g = 0; g < N; g++) begin : g_pack
        assign req_chip_addr[7*g +: 7] = c_chip[g];
        assign req_reg_addr[8*g +: 8]  = c_reg[g];
        assign req_wdata[8*g +: 8]     = c_wd[g];
    end

    i2c_bus_arbiter #(.NUM_REQ(N), .TIMEOUT_CYCLES(50)) dut (
        .clk(clk), .reset(reset), .req(req), .req_rw(req_rw),
        .req_chip_addr(req_chip_addr), .req_reg_addr(req_reg_addr),
        .req_wdata(req_wdata), .grant(grant), .req_done(req_done),
        .rdata(rdata), .rstatus(rstatus), .m_chip_addr(m_chip_addr),
        .m_reg_addr(m_reg_addr), .m_data_in(m_data_in),
        .m_write_en(m_write_en), .m_read_en(m_read_en), .m_done(m_done),
        .m_busy(m_busy), .m_status(m_status), .m_data_out(m_data_out)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Round-robin rule: first requester at or after last_served+1, wrapping.
    function automatic int pick(input logic [N-1:0] r);
        for (int k = 1; k <= N; k++) begin
            if (r[(last_m + k) % N]) return (last_m + k) % N;
        end
        return (last_m + 1) % N;
    endfunction

    task automatic randomize_client(input int c);
        c_chip[c] = 7'($urandom);
        c_reg[c]  = 8'($urandom);
        c_wd[c]   = 8'($urandom);
        req_rw[c] = 1'($urandom);
    endtask

    // Called in the cycle the arbiter is idle and sees the current req.
    task automatic run_txn(input int delay, input bit keep, input bit spur,
                           input logic [2:0] st, input logic [7:0] dout);
        int         w;
        logic [6:0] ec;
        logic [7:0] er, ed;
        logic       erw;
        w   = pick(req);
        ec  = c_chip[w];
        er  = c_reg[w];
        ed  = c_wd[w];
        erw = req_rw[w];
        tick();
        chk("grant", 32'(grant), 32'(1) << w);
        chk("en_early", {m_write_en, m_read_en}, 0);
        if (spur) m_done = 1'b1;
        tick();
        m_done = 1'b0;
        chk("wr_en", m_write_en, !erw);
        chk("rd_en", m_read_en, erw);
        chk("operands", {m_chip_addr, m_reg_addr, m_data_in}, {ec, er, ed});
        chk("done_early", req_done, 0);
        randomize_client(w);
        for (int i = 0; i < delay; i++) begin
            tick();
            chk("en_wait", {m_write_en, m_read_en}, 0);
            chk("hold_ops", {m_chip_addr, m_reg_addr, m_data_in}, {ec, er, ed});
            chk("onehot", 32'($countones(grant)), 1);
        end
        m_status   = st;
        m_data_out = dout;
        m_done     = 1'b1;
        tick();
        m_done     = 1'b0;
        m_data_out = 8'($urandom);
        chk("req_done", 32'(req_done), 32'(1) << w);
        chk("rdata", rdata, dout);
        chk("rstatus", rstatus, st);
        chk("hold_rel", {m_chip_addr, m_reg_addr, m_data_in}, {ec, er, ed});
        tick();
        chk("grant_clr", grant, 0);
        chk("done_clr", req_done, 0);
        last_m = w;
        if (!keep) req[w] = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < N; i++) begin
            c_chip[i] = '0;
            c_reg[i]  = '0;
            c_wd[i]   = '0;
        end
        tick();
        tick();
        chk("rst_grant", grant, 0);
        chk("rst_done", req_done, 0);
        chk("rst_rd", {rdata, rstatus}, 0);
        chk("rst_m", {m_chip_addr, m_reg_addr, m_data_in, m_write_en, m_read_en}, 0);
        reset = 1'b1;
        tick();

        c_chip[0] = 7'h39; c_reg[0] = 8'h41; c_wd[0] = 8'h00; req_rw[0] = 1'b0;
        req[0] = 1'b1;
        run_txn(3, 1'b0, 1'b0, 3'b000, 8'h5a);

        c_chip[1] = 7'h21; c_reg[1] = 8'h42; c_wd[1] = 8'h13; req_rw[1] = 1'b1;
        req[1] = 1'b1;
        run_txn(2, 1'b0, 1'b1, 3'b010, 8'h60);

        m_busy = 1'b1;
        req = 2'b11;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("busy_hold", grant, 0);
        end
        m_busy = 1'b0;

        for (int t = 0; t < 6; t++) begin
            run_txn(int'($urandom_range(0, 4)), 1'b1, 1'b0, 3'($urandom), 8'($urandom));
        end
        req = '0;

        for (int t = 0; t < 8; t++) begin
            for (int c = 0; c < N; c++) randomize_client(c);
            req = N'($urandom_range(1, (1 << N) - 1));
            run_txn(int'($urandom_range(0, 5)), 1'b0, 1'($urandom), 3'($urandom), 8'($urandom));
        end
        req = '0;

        req = 2'b10;
        tick();
        chk("mid_grant", grant, 2'b10);
        tick();
        chk("mid_en", {m_write_en, m_read_en}, {!req_rw[1], req_rw[1]});
        #2;
        reset = 1'b0;
        #1;
        chk("arst_grant", grant, 0);
        chk("arst_en", {m_write_en, m_read_en}, 0);
        chk("arst_done", req_done, 0);
        chk("arst_m", {m_chip_addr, m_reg_addr, m_data_in}, 0);
        tick();
        reset  = 1'b1;
        last_m = N - 1;
        req    = 2'b11;
        run_txn(1, 1'b0, 1'b0, 3'b001, 8'hc3);
        req = '0;

`ifdef I2C_ARB_TIMEOUT_EN
        begin
            int w;
            req = 2'b10;
            w = pick(req);
            tick();
            chk("to_grant", 32'(grant), 32'(1) << w);
            tick();
            for (int i = 0; i < 50; i++) begin
                tick();
                chk("to_early", req_done, 0);
            end
            tick();
            chk("to_done", 32'(req_done), 32'(1) << w);
            chk("to_status", rstatus, 3'b111);
            chk("to_rdata", rdata, 0);
            tick();
            chk("to_grant_clr", grant, 0);
            last_m = w;
            req = 2'b00;
            req[0] = 1'b1;
            run_txn(2, 1'b0, 1'b0, 3'b000, 8'h77);
        end
`endif

        tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
